// File: rtl/vram_cpu_port.sv
// CPU-side port onto the eight 1 KB video RAM banks (dual-port RAM side a).
// Decodes Z80-style strobes in the VRAM window, performs one access per strobe, stalls reads via wait_n.
module vram_cpu_port #(
    parameter logic [2:0]  WIN_BASE = 3'b001,
    parameter int unsigned BANK_AW  = 10
) (
    input  logic               clk,
    input  logic               RESET_n,
    input  logic [15:0]        cpu_a,
    input  logic [7:0]         cpu_din,
    input  logic               mreq_n,
    input  logic               rd_n,
    input  logic               wr_n,
    output logic [7:0]         cpu_dout,
    output logic               vram_cs,
    output logic               wait_n,
    output logic [BANK_AW-1:0] ram_addr,
    output logic [7:0]         ram_data,
    output logic [7:0]         ram_wren,
    input  logic [63:0]        ram_q
);

    typedef enum logic [2:0] {StIdle, StWr, StRd1, StRd2, StDone} state_e;

    state_e             state_q, state_d;
    logic               rd_req_q, rd_req_d;
    logic               wr_req_q, wr_req_d;
    logic [2:0]         bank_q, bank_d;
    logic [7:0]         cpu_dout_q, cpu_dout_d;
    logic               vram_cs_q, vram_cs_d;
    logic               wait_n_q, wait_n_d;
    logic [BANK_AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]         ram_data_q, ram_data_d;
    logic [7:0]         ram_wren_q, ram_wren_d;

    logic               hit, rd_req, wr_req;
    logic [2:0]         bank;
    logic [BANK_AW-1:0] offset;

    assign hit    = !mreq_n && (cpu_a[15:13] == WIN_BASE);
    // Both strobes low at once is treated as no request at all.
    assign rd_req = hit && !rd_n && wr_n;
    assign wr_req = hit && !wr_n && rd_n;
    assign bank   = cpu_a[BANK_AW+2:BANK_AW];
    assign offset = cpu_a[BANK_AW-1:0];

    always_comb begin
        state_d    = state_q;
        rd_req_d   = rd_req;
        wr_req_d   = wr_req;
        bank_d     = bank_q;
        cpu_dout_d = cpu_dout_q;
        vram_cs_d  = vram_cs_q;
        wait_n_d   = wait_n_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren_d = ram_wren_q;
        unique case (state_q)
            StIdle: begin
                if (wr_req && !wr_req_q) begin
                    state_d    = StWr;
                    bank_d     = bank;
                    ram_addr_d = offset;
                    ram_data_d = cpu_din;
                    ram_wren_d = 8'h01 << bank;
                    vram_cs_d  = 1'b1;
                end else if (rd_req && !rd_req_q) begin
                    state_d    = StRd1;
                    bank_d     = bank;
                    ram_addr_d = offset;
                    wait_n_d   = 1'b0;
                    vram_cs_d  = 1'b1;
                end
            end
            StWr: begin
                ram_wren_d = 8'h00;
                state_d    = StDone;
            end
            // RAM registers the address on leaving RD1; its output is valid during RD2.
            StRd1: state_d = StRd2;
            StRd2: begin
                cpu_dout_d = ram_q[{bank_q, 3'b000} +: 8];
                wait_n_d   = 1'b1;
                state_d    = StDone;
            end
            StDone: begin
                if (!rd_req && !wr_req) begin
                    vram_cs_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                ram_wren_d = 8'h00;
                wait_n_d   = 1'b1;
                vram_cs_d  = 1'b0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= StIdle;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            bank_q     <= 3'd0;
            cpu_dout_q <= 8'hFF;
            vram_cs_q  <= 1'b0;
            wait_n_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_data_q <= 8'h00;
            ram_wren_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            bank_q     <= bank_d;
            cpu_dout_q <= cpu_dout_d;
            vram_cs_q  <= vram_cs_d;
            wait_n_q   <= wait_n_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
        end
    end

    assign cpu_dout = cpu_dout_q;
    assign vram_cs  = vram_cs_q;
    assign wait_n   = wait_n_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_wren = ram_wren_q;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Directed bench for vram_cpu_port: models the side-a dpram and counts write pulses
// and wait cycles on the falling clock edge.
module tb_vram_cpu_port;

    logic        clk = 1'b0;
    logic        RESET_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        mreq_n, rd_n, wr_n;
    logic [7:0]  cpu_dout;
    logic        vram_cs, wait_n;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  ram_wren;
    logic [63:0] ram_q;

    int n_checks = 0;
    int n_errors = 0;

    vram_cpu_port dut (
        .clk      (clk),
        .RESET_n  (RESET_n),
        .cpu_a    (cpu_a),
        .cpu_din  (cpu_din),
        .mreq_n   (mreq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .cpu_dout (cpu_dout),
        .vram_cs  (vram_cs),
        .wait_n   (wait_n),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    // Side-a dpram model: registered read, per-bank write enable.
    logic [7:0] mem [8][1024];
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (ram_wren[b]) mem[b][ram_addr] <= ram_data;
            ram_q[b*8 +: 8] <= mem[b][ram_addr];
        end
    end

    int         wren_cycles = 0;
    int         wait_cycles = 0;
    logic [7:0] last_wren = 8'h00;
    logic [7:0] last_data = 8'h00;
    logic [9:0] last_addr = 10'h000;
    always @(negedge clk) begin
        if (RESET_n) begin
            if (ram_wren != 8'h00) begin
                wren_cycles <= wren_cycles + 1;
                last_wren   <= ram_wren;
                last_data   <= ram_data;
                last_addr   <= ram_addr;
            end
            if (!wait_n) wait_cycles <= wait_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic [7:0] d,
                       input logic m, input logic r, input logic w);
        cpu_a   = a;
        cpu_din = d;
        mreq_n  = m;
        rd_n    = r;
        wr_n    = w;
    endtask

    task automatic idle_bus();
        bus(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1);
    endtask

    int wr0, wt0;

    initial begin
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 1024; i++) mem[b][i] = 8'h00;
        ram_q   = 64'h0;
        RESET_n = 1'b0;
        idle_bus();
        #12;
        check("rst_dout", {24'h0, cpu_dout}, 32'hFF);
        check("rst_cs", {31'h0, vram_cs}, 32'h0);
        check("rst_wait", {31'h0, wait_n}, 32'h1);
        check("rst_addr", {22'h0, ram_addr}, 32'h0);
        check("rst_data", {24'h0, ram_data}, 32'h0);
        check("rst_wren", {24'h0, ram_wren}, 32'h0);
        RESET_n = 1'b1;
        tick();

        // 1: write A5 @0x2000
        wr0 = wren_cycles; wt0 = wait_cycles;
        bus(16'h2000, 8'hA5, 1'b0, 1'b1, 1'b0);
        tick();
        check("t1_wren", {24'h0, ram_wren}, 32'h01);
        check("t1_addr", {22'h0, ram_addr}, 32'h000);
        check("t1_data", {24'h0, ram_data}, 32'hA5);
        check("t1_cs", {31'h0, vram_cs}, 32'h1);
        tick();
        check("t1_wren_off", {24'h0, ram_wren}, 32'h00);
        idle_bus();
        tick();
        check("t1_cs_off", {31'h0, vram_cs}, 32'h0);
        check("t1_pulses", wren_cycles - wr0, 32'd1);
        check("t1_nowait", wait_cycles - wt0, 32'd0);
        check("t1_mem", {24'h0, mem[0][0]}, 32'hA5);

        // 3: accesses just outside the window
        wr0 = wren_cycles; wt0 = wait_cycles;
        bus(16'h1FFF, 8'h55, 1'b0, 1'b1, 1'b0); tick(); tick(); idle_bus(); tick();
        bus(16'h1FFF, 8'h55, 1'b0, 1'b0, 1'b1); tick(); tick(); idle_bus(); tick();
        bus(16'h4000, 8'h66, 1'b0, 1'b1, 1'b0); tick(); tick(); idle_bus(); tick();
        bus(16'h4000, 8'h66, 1'b0, 1'b0, 1'b1); tick(); tick();
        check("t3_cs", {31'h0, vram_cs}, 32'h0);
        idle_bus(); tick();
        check("t3_pulses", wren_cycles - wr0, 32'd0);
        check("t3_wait", wait_cycles - wt0, 32'd0);
        check("t3_dout", {24'h0, cpu_dout}, 32'hFF);

        // 4: rd_n and wr_n both low
        wr0 = wren_cycles; wt0 = wait_cycles;
        bus(16'h2400, 8'h77, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        check("t4_cs", {31'h0, vram_cs}, 32'h0);
        check("t4_wait_n", {31'h0, wait_n}, 32'h1);
        idle_bus(); tick();
        check("t4_pulses", wren_cycles - wr0, 32'd0);
        check("t4_wait", wait_cycles - wt0, 32'd0);

        // 5: write held 10 clks with changing data
        wr0 = wren_cycles;
        for (int i = 0; i < 10; i++) begin
            bus(16'h2801, 8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
            tick();
        end
        check("t5_cs_held", {31'h0, vram_cs}, 32'h1);
        idle_bus(); tick();
        check("t5_pulses", wren_cycles - wr0, 32'd1);
        check("t5_wren", {24'h0, last_wren}, 32'h04);
        check("t5_data", {24'h0, last_data}, 32'h10);
        check("t5_addr", {22'h0, last_addr}, 32'h001);
        check("t5_cs_off", {31'h0, vram_cs}, 32'h0);

        // 2: write 3C @0x3FFF, then read it back
        wr0 = wren_cycles;
        bus(16'h3FFF, 8'h3C, 1'b0, 1'b1, 1'b0);
        tick();
        check("t2_wren", {24'h0, ram_wren}, 32'h80);
        check("t2_addr", {22'h0, ram_addr}, 32'h3FF);
        tick(); idle_bus(); tick();
        check("t2_pulses", wren_cycles - wr0, 32'd1);
        check("t2_mem6", {24'h0, mem[6][1023]}, 32'h00);
        wt0 = wait_cycles;
        bus(16'h3FFF, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check("t2_wait_rd1", {31'h0, wait_n}, 32'h0);
        bus(16'h2000, 8'h00, 1'b0, 1'b0, 1'b1); // bank must stay latched
        tick();
        check("t2_wait_rd2", {31'h0, wait_n}, 32'h0);
        tick();
        check("t2_wait_rel", {31'h0, wait_n}, 32'h1);
        check("t2_dout", {24'h0, cpu_dout}, 32'h3C);
        idle_bus(); tick();
        check("t2_wait_cnt", wait_cycles - wt0, 32'd2);
        check("t2_cs_off", {31'h0, vram_cs}, 32'h0);

        // strobe released during RD1: read still completes
        bus(16'h2801, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        idle_bus();
        tick(); tick();
        check("rel_dout", {24'h0, cpu_dout}, 32'h10);
        check("rel_wait", {31'h0, wait_n}, 32'h1);
        check("rel_cs_done", {31'h0, vram_cs}, 32'h1);
        tick();
        check("rel_cs_idle", {31'h0, vram_cs}, 32'h0);

        // 6: reset pulsed during RD2
        bus(16'h3FFF, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        check("t6_in_rd2", {31'h0, wait_n}, 32'h0);
        #1 RESET_n = 1'b0;
        #1;
        check("t6_wait", {31'h0, wait_n}, 32'h1);
        check("t6_wren", {24'h0, ram_wren}, 32'h00);
        check("t6_dout", {24'h0, cpu_dout}, 32'hFF);
        check("t6_cs", {31'h0, vram_cs}, 32'h0);
        idle_bus();
        #1 RESET_n = 1'b1;
        tick();
        wt0 = wait_cycles;
        bus(16'h2000, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); tick(); tick();
        check("t6_rd_dout", {24'h0, cpu_dout}, 32'hA5);
        idle_bus(); tick();
        check("t6_rd_wait", wait_cycles - wt0, 32'd2);
        check("t6_cs_idle", {31'h0, vram_cs}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
